// File: rtl/vpu_alu_si_add_sub_pipe_pkg.sv
// Shared widths and the per-beat control bundle for the VPU signed-integer
// add/subtract pipeline.
package vpu_alu_si_add_sub_pipe_pkg;

  localparam int unsigned OPERAND_WIDTH    = 32;
  localparam int unsigned SRAM_R_PORT_CNT  = 3;
  localparam int unsigned VPU_ALU_LANE_CNT = 4;

  typedef struct packed {
    logic sub_n;
    logic sat_en;
    logic use_op2;
  } alu_ctrl_t;

endpackage

// File: rtl/vpu_alu_si_add_sub_pipe_if.sv
// Source-side and destination-side handshake bundle of the add/sub pipeline.
// slave = the ALU's view, master = the driver/consumer view.
interface vpu_alu_si_add_sub_pipe_if
  import vpu_alu_si_add_sub_pipe_pkg::*;
#(
  parameter int unsigned OPERAND_W = OPERAND_WIDTH,
  parameter int unsigned LANE_N    = VPU_ALU_LANE_CNT,
  parameter int unsigned RPORT_N   = SRAM_R_PORT_CNT
);

  logic                          in_valid;
  logic                          in_ready;
  logic [LANE_N*OPERAND_W-1:0]   op_0;
  logic [LANE_N*OPERAND_W-1:0]   op_1;
  logic [LANE_N*OPERAND_W-1:0]   op_2;
  logic [RPORT_N-1:0]            op_valid;
  logic                          sub_n;
  logic                          sat_en;
  logic                          out_valid;
  logic                          out_ready;
  logic [LANE_N*OPERAND_W-1:0]   result_o;
  logic [LANE_N-1:0]             ovf_o;

  modport slave (
    input  in_valid, op_0, op_1, op_2, op_valid, sub_n, sat_en, out_ready,
    output in_ready, out_valid, result_o, ovf_o
  );

  modport master (
    output in_valid, op_0, op_1, op_2, op_valid, sub_n, sat_en, out_ready,
    input  in_ready, out_valid, result_o, ovf_o
  );

endinterface

// File: rtl/vpu_alu_si_lane_sat.sv
// One lane of stage 2: reduces an exact (W+2)-bit signed sum to a W-bit
// result, saturating or wrapping, and flags out-of-range sums.
module vpu_alu_si_lane_sat
  import vpu_alu_si_add_sub_pipe_pkg::*;
#(
  parameter int unsigned W = OPERAND_WIDTH
) (
  input  logic [W+1:0] sum_i,
  input  logic         sat_en_i,
  output logic [W-1:0] res_o,
  output logic         ovf_o
);

  logic ovf_pos;
  logic ovf_neg;

  // In range exactly when the top three bits are all equal.
  assign ovf_pos = !sum_i[W+1] &&  (|sum_i[W:W-1]);
  assign ovf_neg =  sum_i[W+1] && !(&sum_i[W:W-1]);
  assign ovf_o   = ovf_pos || ovf_neg;

  always_comb begin
    // NOTE: default first so every path assigns res_o and no latch is inferred.
    res_o = sum_i[W-1:0];
    if (sat_en_i && ovf_pos) begin
      res_o = {1'b0, {(W-1){1'b1}}};
    end else if (sat_en_i && ovf_neg) begin
      res_o = {1'b1, {(W-1){1'b0}}};
    end
  end

endmodule

// File: rtl/vpu_alu_si_add_sub_pipe.sv
// Two-stage valid/ready multi-lane signed op_0 +/- op_1 +/- op_2 unit with
// optional saturation and per-lane overflow flags.
module vpu_alu_si_add_sub_pipe
  import vpu_alu_si_add_sub_pipe_pkg::*;
#(
  parameter int unsigned OPERAND_W = OPERAND_WIDTH,
  parameter int unsigned LANE_N    = VPU_ALU_LANE_CNT,
  parameter int unsigned RPORT_N   = SRAM_R_PORT_CNT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  vpu_alu_si_add_sub_pipe_if.slave   bus
);

  localparam int unsigned W  = OPERAND_W;
  localparam int unsigned XW = OPERAND_W + 2;

  logic                   v1_q, v2_q;
  logic                   accept, s2_load;
  alu_ctrl_t              ctrl_d;
  logic                   sat_q;
  logic [LANE_N*XW-1:0]   s1_d, s1_q;
  logic [LANE_N*XW-1:0]   op2t_d, op2t_q;
  logic [LANE_N*W-1:0]    res_d, res_q;
  logic [LANE_N-1:0]      ovf_d, ovf_q;
  logic                   unused_op_valid;

  assign bus.in_ready = !v1_q || !v2_q || bus.out_ready;
  assign accept       = bus.in_valid && en && bus.in_ready;
  assign s2_load      = v1_q && (!v2_q || bus.out_ready);

  assign ctrl_d.sub_n   = bus.sub_n;
  assign ctrl_d.sat_en  = bus.sat_en;
  assign ctrl_d.use_op2 = bus.op_valid[RPORT_N-1];
  // Only the last read port gates op_2; the others are informational here.
  assign unused_op_valid = ^bus.op_valid;

  for (genvar i = 0; i < LANE_N; i++) begin : g_lane
    logic [W-1:0]  a, b, c;
    logic [XW-1:0] xa, xb, xc, nb, nc, s2;

    assign a  = bus.op_0[i*W +: W];
    assign b  = bus.op_1[i*W +: W];
    assign c  = bus.op_2[i*W +: W];
    assign xa = {{2{a[W-1]}}, a};
    assign xb = {{2{b[W-1]}}, b};
    assign xc = {{2{c[W-1]}}, c};
    // Negating on the widened value keeps -2^(W-1) exact.
    assign nb = ~xb + XW'(1);
    assign nc = ~xc + XW'(1);

    assign s1_d[i*XW +: XW]   = xa + (ctrl_d.sub_n ? xb : nb);
    assign op2t_d[i*XW +: XW] = ctrl_d.use_op2 ? (ctrl_d.sub_n ? xc : nc) : '0;

    assign s2 = s1_q[i*XW +: XW] + op2t_q[i*XW +: XW];

    vpu_alu_si_lane_sat #(.W(W)) u_lane_sat (
      .sum_i    (s2),
      .sat_en_i (sat_q),
      .res_o    (res_d[i*W +: W]),
      .ovf_o    (ovf_d[i])
    );
  end

  // NOTE: stage-1 data is qualified by v1_q, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_q   <= s1_d;
      op2t_q <= op2t_d;
      sat_q  <= ctrl_d.sat_en;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      res_q <= '0;
      ovf_q <= '0;
    end else begin
      if (bus.in_ready) begin
        v1_q <= bus.in_valid && en;
      end
      if (s2_load) begin
        v2_q  <= 1'b1;
        res_q <= res_d;
        ovf_q <= ovf_d;
      end else if (bus.out_ready) begin
        v2_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = v2_q;
  assign bus.result_o  = res_q;
  assign bus.ovf_o     = ovf_q;

endmodule

// File: tb/tb_vpu_alu_si_add_sub_pipe.sv
// Scoreboard bench for the 2-lane, 8-bit add/sub pipeline: directed beats push
// hand-computed results; a negedge monitor pops and compares on each retire.
module tb_vpu_alu_si_add_sub_pipe;

  localparam int W = 8;
  localparam int L = 2;
  localparam int P = 3;

  logic clk;
  logic rst_n;
  logic en;

  vpu_alu_si_add_sub_pipe_if #(.OPERAND_W(W), .LANE_N(L), .RPORT_N(P)) bus ();

  vpu_alu_si_add_sub_pipe #(.OPERAND_W(W), .LANE_N(L), .RPORT_N(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [1:0]  ovf;
    int          t;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] p2(input int l1, input int l0);
    return {8'(l1), 8'(l0)};
  endfunction

  // Monitor: compare on retire, and check output stability during stalls.
  exp_t        e;
  bit          prev_stall = 1'b0;
  logic [15:0] held_res;
  logic [1:0]  held_ovf;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_result", bus.result_o, held_res);
        check("hold_ovf", bus.ovf_o, held_ovf);
      end
      if (bus.out_valid && bus.out_ready) begin
        check("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("result", bus.result_o, e.res);
          check("ovf", bus.ovf_o, e.ovf);
          if (e.lat) check("latency", cyc - e.t, 2);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      held_res   = bus.result_o;
      held_ovf   = bus.ovf_o;
    end
  end

  // Offer one beat; in_ready is sampled at negedge, where it is stable.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                      input logic [2:0] opv, input logic sub_n, input logic sat,
                      input logic [15:0] er, input logic [1:0] eo, input bit lat);
    bit rdy = 1'b0;
    int n   = 0;
    bus.op_0 = a;  bus.op_1 = b;  bus.op_2 = c;
    bus.op_valid = opv;  bus.sub_n = sub_n;  bus.sat_en = sat;
    bus.in_valid = 1'b1;
    while (!rdy && n < 40) begin
      @(negedge clk);
      rdy = bus.in_ready;
      if (rdy) sb.push_back('{res: er, ovf: eo, t: cyc, lat: lat});
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy) check("accept_timeout", {31'd0, rdy}, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;  bus.op_0 = '0;  bus.op_1 = '0;  bus.op_2 = '0;
    bus.op_valid = '0;    bus.sub_n = 1'b1;  bus.sat_en = 1'b0;
    bus.out_ready = 1'b1;
    en    = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result_o, 0);
    check("rst_ovf", bus.ovf_o, 0);
    check("rst_in_ready", bus.in_ready, 1);
    cycles(2);
    rst_n = 1'b1;
    en    = 1'b1;

    // Directed vectors, back to back, lanes packed as p2(lane1, lane0).
    send(p2(1, 10),    p2(2, 20),    p2(3, 5),     3'b100, 1, 0, p2(6, 35),     2'b00, 1);
    send(p2(1, 10),    p2(2, 20),    p2(3, 5),     3'b011, 1, 0, p2(3, 30),     2'b00, 1);
    send(p2(5, 0),     p2(3, -128),  p2(1, 0),     3'b100, 0, 1, p2(1, 127),    2'b01, 1);
    send(p2(5, 0),     p2(3, -128),  p2(1, 0),     3'b100, 0, 0, p2(1, -128),   2'b01, 1);
    send(p2(1, -100),  p2(1, -100),  p2(1, -100),  3'b111, 1, 1, p2(3, -128),   2'b01, 1);
    send(p2(-1, 100),  p2(-1, 100),  p2(-1, 0),    3'b100, 1, 0, p2(-3, -56),   2'b01, 1);
    send(p2(127, -128), p2(-128, 127), p2(0, 127), 3'b100, 0, 1, p2(127, -128), 2'b11, 1);
    send(p2(0, 10),    p2(0, 20),    p2(99, 99),   3'b000, 0, 0, p2(0, -10),    2'b00, 1);
    cycles(4);

    // Backpressure: out_ready low for 4 cycles while 5 beats stream in.
    fork
      begin
        for (int k = 1; k <= 5; k++)
          send(p2(2*k, k), p2(1, 1), p2(0, 0), 3'b000, 1, 0, p2(2*k+1, k+1), 2'b00, 0);
      end
      begin
        bus.out_ready = 1'b0;
        cycles(1);
        cycles(1);
        check("bp_in_ready_low_a", bus.in_ready, 0);
        cycles(1);
        check("bp_in_ready_low_b", bus.in_ready, 0);
        check("bp_out_valid", bus.out_valid, 1);
        cycles(1);
        bus.out_ready = 1'b1;
      end
    join
    cycles(5);

    // en=0 blocks new beats but lets the in-flight one drain.
    send(p2(7, 40), p2(1, 2), p2(1, 1), 3'b100, 1, 0, p2(9, 43), 2'b00, 1);
    en = 1'b0;
    bus.op_0 = p2(9, 9);
    bus.in_valid = 1'b1;
    cycles(5);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("en0_no_output", bus.out_valid, 0);
    check("en0_drained", sb.size(), 0);
    @(posedge clk);
    #1;
    en = 1'b1;

    // Reset with two beats held in a stalled pipeline.
    bus.out_ready = 1'b0;
    send(p2(3, 50), p2(3, 5), p2(0, 0), 3'b000, 1, 0, p2(6, 55), 2'b00, 0);
    send(p2(4, 60), p2(4, 6), p2(0, 0), 3'b000, 1, 0, p2(8, 66), 2'b00, 0);
    check("pre_rst_full", bus.in_ready, 0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_result", bus.result_o, 0);
    check("mid_rst_ovf", bus.ovf_o, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    bus.op_0 = p2(11, 11);
    bus.in_valid = 1'b1;
    cycles(2);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(p2(-2, 1), p2(-3, 2), p2(-4, 3), 3'b100, 1, 0, p2(-9, 6), 2'b00, 1);

    for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge clk);
    cycles(2);
    check("final_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vpu_alu_si_add_sub_pipe.md
# vpu_alu_si_add_sub_pipe

Pipelined, multi-lane signed-integer add/subtract unit for the VPU ALU. It computes op_0 ± op_1 ± op_2 per lane, with op_2 included only when the last SRAM read port is valid. It adds an optional saturation mode and per-lane overflow flags, and passes data through a 2-stage valid/ready pipeline. It sits between the VPU source ports and VPU_DST_PORT and is enabled by VPU_CONTROLLER.

## Interface
- OPERAND_WIDTH, 32: bits per lane operand and per lane result.
- LANE_CNT, 4: independent lanes processed per beat.
- SRAM_R_PORT_CNT, 3: width of op_valid; bit SRAM_R_PORT_CNT-1 gates op_2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  controller enable; in_valid is ignored when en=0.
- in_valid  input  1  beat present on operand inputs.
- in_ready  output  1  unit accepts beat this cycle.
- op_0, op_1, op_2  input  LANE_CNT*OPERAND_WIDTH  packed signed lanes; lane i occupies bits [i*W +: W].
- op_valid  input  SRAM_R_PORT_CNT  per-port validity; only the MSB is used.
- sub_n  input  1  0 = subtract op_1 and op_2, 1 = add.
- sat_en  input  1  1 = saturate on overflow, 0 = wrap.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts beat.
- result_o  output  LANE_CNT*OPERAND_WIDTH  packed signed results.
- ovf_o  output  LANE_CNT  per-lane overflow, qualified by out_valid.

## Operation
- Accept: a beat is taken when in_valid & en & in_ready. sub_n, sat_en and op_valid MSB are sampled with the beat and travel with it.
- Stage 1, per lane:
  - Sign-extend op_0 and op_1 to W+2 bits.
  - Negation is true two's complement (~x + 1) on the extended value, so negating -2^(W-1) is exact.
  - Register s1 = op_0 ± op_1, the extended op_2 term (negated if sub_n=0, zero if the op_2 flag is 0), and the sampled control bits.
- Stage 2, per lane:
  - Exact sum s2 = s1 + op2_term in W+2 bits.
  - Overflow ovf = (s2 > 2^(W-1)-1) or (s2 < -2^(W-1)).
  - With sat_en=1, clamp to the W-bit maximum or minimum. With sat_en=0, truncate to the low W bits.
  - Register result and ovf.
- Lanes are fully independent; there is no carry between lanes.
- en=0 blocks new acceptance only. Beats already in the pipeline still drain normally.

## Timing
- Latency: 2 cycles from acceptance to out_valid with no backpressure.
- Throughput: 1 beat per cycle.
- Stage valid bits v1 and v2:
  - Stage 2 loads when v1 & (!v2 | out_ready).
  - Stage 1 loads when in_ready.
  - in_ready = !v1 | !v2 | out_ready. It depends combinationally on out_ready; there is no combinational path from in_valid.
- Output handshake:
  - While out_valid=1 and out_ready=0, result_o, ovf_o and out_valid hold stable.
  - A beat retires on out_valid & out_ready.
- Full pipeline: with both stages valid and out_ready=0, in_ready=0 and no beat is lost or duplicated.
- Simultaneous events: when a beat retires and another arrives in the same cycle, both transfers occur.
- Reset, asserted at any time including mid-stall:
  - Immediately clears v1 and v2; out_valid=0, result_o=0, ovf_o=0.
  - in_ready=1 during reset, but no beat is accepted while rst_n=0.
  - In-flight beats are discarded.
- Data registers need no reset apart from the output registers.

## Structure
- VPU_PKG holds OPERAND_WIDTH, SRAM_R_PORT_CNT and a new VPU_ALU_LANE_CNT default. It also holds a typedef for the per-beat control bundle (sub_n, sat_en, use_op2).
- One sub-module, vpu_alu_si_lane_sat: combinational W+2-bit sum to W-bit result plus ovf. It is instantiated LANE_CNT times in stage 2.
- Pipeline control lives in the top module only.

## Test plan
All scenarios use OPERAND_WIDTH=8 and LANE_CNT=2.
- Add, op_2 included: op_0=10, op_1=20, op_2=5, op_valid MSB=1, sub_n=1 -> result 35 two cycles later, ovf=0.
- Op_2 excluded: same operands with op_valid MSB=0 -> result 30.
- Subtract, most-negative edge: op_0=0, op_1=-128, op_2=0, sub_n=0:
  - sat_en=1 -> result 127, ovf=1.
  - sat_en=0 -> result -128, ovf=1.
- Negative saturation: op_0=-100, op_1=-100, op_2=-100, add, sat_en=1 -> result -128, ovf=1. Lane 1 with 1+1+1 gives 3, ovf=0, unaffected.
- Backpressure: stream 5 beats with out_ready held low for 4 cycles mid-stream.
  - in_ready drops after 2 beats are held.
  - All 5 results emerge in order, with no loss or duplication.
  - Outputs stay stable while stalled.
- Reset mid-operation: assert rst_n=0 with 2 beats in flight -> out_valid=0 and result_o=0 immediately. After release, the first new beat appears after 2 cycles.
